// File: rtl/fft8_out_serializer_pkg.sv
// Shared constants and FSM encoding for the 8-point FFT output serializer.
package fft8_out_serializer_pkg;
    localparam int FFT_N   = 28;
    localparam int FFT_PTS = 8;
    localparam int FFT_W   = 2 * FFT_N + 8;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } fsm_state_t;
endpackage

// File: rtl/fft_scale_shr3.sv
// Optional divide-by-8 of one signed component (arithmetic shift, floor rounding).
module fft_scale_shr3 #(
    parameter int W = 32
) (
    input  logic signed [W-1:0] d,
    input  logic                en,
    output logic signed [W-1:0] q
);
    assign q = en ? (d >>> 3) : d;
endmodule

// File: rtl/fft8_out_serializer.sv
// Captures one 8-bin FFT frame and streams it out bin 0..7 over a valid/ready port.
import fft8_out_serializer_pkg::*;

module fft8_out_serializer #(
    parameter logic [4:0] N = 5'd28
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*N+7:0]      x0,
    input  logic [2*N+7:0]      x1,
    input  logic [2*N+7:0]      x2,
    input  logic [2*N+7:0]      x3,
    input  logic [2*N+7:0]      x4,
    input  logic [2*N+7:0]      x5,
    input  logic [2*N+7:0]      x6,
    input  logic [2*N+7:0]      x7,
    input  logic                in_valid,
    input  logic                ifft_scale,
    output logic                stall,
    output logic [2*N+7:0]      out_data,
    output logic [2:0]          out_index,
    output logic                out_valid,
    output logic                out_last,
    input  logic                out_ready,
    output logic [15:0]         frame_cnt
);
    localparam int W  = 2 * N + 8;
    localparam int CW = N + 4;

    fsm_state_t state, state_nxt;
    logic [FFT_PTS-1:0][W-1:0] xin, xsc, frame_buf;
    logic [2:0]   idx_nxt;
    logic         vld_nxt, last_nxt;
    logic [W-1:0] data_nxt;
    logic [15:0]  cnt_q;
    logic         advance, accept_last, capture;

    assign xin = {x7, x6, x5, x4, x3, x2, x1, x0};

    for (genvar k = 0; k < FFT_PTS; k++) begin : g_scale
        fft_scale_shr3 #(.W(CW)) u_re (
            .d (xin[k][W-1:CW]),
            .en(ifft_scale),
            .q (xsc[k][W-1:CW])
        );
        fft_scale_shr3 #(.W(CW)) u_im (
            .d (xin[k][CW-1:0]),
            .en(ifft_scale),
            .q (xsc[k][CW-1:0])
        );
    end

    assign advance     = out_valid && out_ready;
    assign accept_last = advance && out_last;
    assign stall       = (state == DRAIN) && !accept_last;
    assign capture     = in_valid && !stall;
    assign frame_cnt   = cnt_q;

    always_comb begin
        state_nxt = state;
        idx_nxt   = out_index;
        data_nxt  = out_data;
        case (state)
            IDLE:    if (capture) state_nxt = DRAIN;
            DRAIN:   if (accept_last && !capture) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        vld_nxt = (state_nxt == DRAIN);
        // The first beat of a new frame comes straight from the scaled inputs,
        // since the buffer is only written at this same edge.
        if (capture) begin
            idx_nxt  = '0;
            data_nxt = xsc[0];
        end else if (advance) begin
            idx_nxt = out_index + 3'd1;
            if (vld_nxt) data_nxt = frame_buf[idx_nxt];
        end
        last_nxt = vld_nxt && (idx_nxt == 3'd7);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_index <= '0;
            out_data  <= '0;
            cnt_q     <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= vld_nxt;
            out_last  <= last_nxt;
            out_index <= idx_nxt;
            out_data  <= data_nxt;
            if (accept_last) cnt_q <= cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) frame_buf <= xsc;
    end
endmodule

// File: tb/tb_fft8_out_serializer.sv
// Scoreboard bench: stimulus pushes model beats, a negedge monitor pops and compares.
module tb_fft8_out_serializer;
    localparam int W = 64;

    typedef struct packed {
        logic [W-1:0] d;
        logic [2:0]   i;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] x [8];
    logic         in_valid = 1'b0, ifft_scale = 1'b0, out_ready = 1'b1;
    logic         stall, out_valid, out_last;
    logic [W-1:0] out_data;
    logic [2:0]   out_index;
    logic [15:0]  frame_cnt;

    int           compared = 0, mismatched = 0;
    int           ready_mode = 0;
    beat_t        exp_q [$];
    logic [15:0]  exp_cnt = 16'd0;
    logic [W-1:0] ex [8];

    always #5 clk = ~clk;

    fft8_out_serializer #(.N(5'd28)) dut (
        .clk(clk), .rst(rst),
        .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]),
        .x4(x[4]), .x5(x[5]), .x6(x[6]), .x7(x[7]),
        .in_valid(in_valid), .ifft_scale(ifft_scale), .stall(stall),
        .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready), .frame_cnt(frame_cnt)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Floor division by 8 of a signed 32-bit component.
    function automatic logic [31:0] div8(input logic [31:0] v);
        int s, m;
        s = signed'(v);
        m = ((s % 8) + 8) % 8;
        return 32'((s - m) / 8);
    endfunction

    function automatic logic [W-1:0] model_word(input logic [W-1:0] w, input logic sc);
        if (!sc) return w;
        return {div8(w[63:32]), div8(w[31:0])};
    endfunction

    task automatic model_frame(input logic sc);
        for (int k = 0; k < 8; k++) ex[k] = model_word(x[k], sc);
    endtask

    // Present the frame in x[] (expected beats in ex[]), hold until captured.
    task automatic send_frame(input logic sc);
        bit done = 0;
        for (int k = 0; k < 8; k++) exp_q.push_back('{d: ex[k], i: 3'(k)});
        in_valid   = 1'b1;
        ifft_scale = sc;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (!stall) done = 1;
            @(posedge clk); #1;
        end
        if (!done) chk("capture_timeout", 64'd0, 64'd1);
        in_valid   = 1'b0;
        ifft_scale = 1'b0;
    endtask

    task automatic rand_frame();
        for (int k = 0; k < 8; k++) x[k] = {$urandom(), $urandom()};
    endtask

    task automatic drain();
        bit done = 0;
        for (int n = 0; n < 2000 && !done; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) done = 1;
        end
        if (!done) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int ph = 0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                1: begin out_ready = (ph == 0); ph = (ph + 1) % 3; end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    initial begin
        logic         hold = 1'b0;
        logic [W+3:0] held = '0;
        beat_t        b;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) chk("hold_stable", 64'({out_data[59:0], out_last, out_index}), 64'(held));
                if (out_valid) chk("last_flag", 64'(out_last), 64'(out_index == 3'd7));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'(out_index), 64'hFFFF);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_index", 64'(out_index), 64'(b.i));
                        chk("beat_data", out_data, b.d);
                        if (b.i == 3'd7) exp_cnt = exp_cnt + 16'd1;
                    end
                end
                hold = out_valid && !out_ready;
                held = {out_data[59:0], out_last, out_index};
            end
        end
    end

    initial begin
        for (int k = 0; k < 8; k++) x[k] = '0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_cnt", 64'(frame_cnt), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Single frame, exact cycle timing.
        for (int k = 0; k < 8; k++) x[k] = {32'(k + 1), 32'(-(k + 1))};
        model_frame(1'b0);
        send_frame(1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("sf_valid", 64'(out_valid), 64'd1);
            chk("sf_index", 64'(out_index), 64'(i));
            chk("sf_stall", 64'(stall), 64'(i < 7));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("sf_idle", 64'(out_valid), 64'd0);
        chk("sf_cnt", 64'(frame_cnt), 64'd1);
        @(posedge clk); #1;

        // Reset in the middle of a frame, at beat 3.
        rand_frame(); model_frame(1'b0);
        send_frame(1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_stall", 64'(stall), 64'd0);
        chk("mid_rst_cnt", 64'(frame_cnt), 64'd0);
        exp_q.delete();
        exp_cnt = 16'd0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_quiet", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;

        // Back-to-back frames with no bubble.
        rand_frame(); model_frame(1'b0);
        send_frame(1'b0);
        rand_frame(); model_frame(1'b0);
        send_frame(1'b0);
        @(negedge clk);
        chk("b2b_valid", 64'(out_valid), 64'd1);
        chk("b2b_index", 64'(out_index), 64'd0);
        drain();

        // Divide-by-8 with hand-computed bin 3.
        rand_frame();
        x[3] = {32'hFFFF_FFF7, 32'd17};
        model_frame(1'b1);
        ex[3] = {32'hFFFF_FFFE, 32'd2};
        send_frame(1'b1);
        drain();

        // Backpressure pattern 1,0,0.
        ready_mode = 1;
        repeat (2) begin
            rand_frame(); model_frame(1'b0);
            send_frame(1'b0);
        end
        drain();

        // Random frames, random scaling, random ready, random gaps.
        ready_mode = 2;
        for (int f = 0; f < 30; f++) begin
            logic sc;
            sc = 1'($urandom_range(0, 1));
            rand_frame(); model_frame(sc);
            send_frame(sc);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1 chk("rand_cnt", 64'(frame_cnt), 64'(exp_cnt));

        // Counter wrap from 65535.
        force dut.cnt_q = 16'hFFFF;
        #1 release dut.cnt_q;
        exp_cnt = 16'hFFFF;
        chk("wrap_preload", 64'(frame_cnt), 64'hFFFF);
        @(posedge clk); #1;
        rand_frame(); model_frame(1'b0);
        send_frame(1'b0);
        drain();
        chk("wrap_cnt", 64'(frame_cnt), 64'd0);
        chk("wrap_model", 64'(frame_cnt), 64'(exp_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
